// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, instruction geometry and opcodes.
// Optional build macro used by the fetch unit: FETCH_PERF_CNT_EN.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetchState_e;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/stall event counters for the fetch unit; frozen while fetch is halted.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        fetchEv,
  input  logic        stallEv,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else if (!freeze) begin
      if (fetchEv) perf_fetched <= satInc(perf_fetched);
      if (stallEv) perf_stall   <= satInc(perf_stall);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: owns the PC, req/ack to imem, valid/ready to decode, branch redirects.
// Build option FETCH_PERF_CNT_EN adds perf_fetched/perf_stall counter outputs.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 64,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               dec_ready,
  input  logic               inv_op,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted,
  output logic               misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);

  fetchState_e       state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pendPc;
  logic              drop;

  logic redirOk;
  logic redirBad;
  logic accept;

  assign redirOk   = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redirBad  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign accept    = dec_valid && dec_ready;
  assign imem_addr = pc;

  // A redirect seen mid-request parks its target in pendPc so imem_addr stays put until the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RST_PC;
      pendPc    <= RST_PC;
      drop      <= 1'b0;
      imem_req  <= 1'b0;
      dec_valid <= 1'b0;
      dec_instr <= '0;
      dec_pc    <= RST_PC;
      halted    <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (redirBad) begin
            state    <= HALT;
            imem_req <= 1'b0;
            halted   <= 1'b1;
            misalign <= 1'b1;
          end else if (redirOk) begin
            if (imem_ack) begin
              pc   <= redirect_pc;
              drop <= 1'b0;
            end else begin
              pendPc <= redirect_pc;
              drop   <= 1'b1;
            end
          end else if (imem_ack) begin
            if (drop) begin
              pc   <= pendPc;
              drop <= 1'b0;
            end else begin
              dec_instr <= imem_rdata;
              dec_pc    <= pc;
              dec_valid <= 1'b1;
              imem_req  <= 1'b0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirBad) begin
            state     <= HALT;
            dec_valid <= 1'b0;
            halted    <= 1'b1;
            misalign  <= 1'b1;
          end else if (redirOk) begin
            pc        <= redirect_pc;
            dec_valid <= 1'b0;
            imem_req  <= 1'b1;
            state     <= REQ;
          end else if (accept) begin
            dec_valid <= 1'b0;
            if (inv_op) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc       <= pc + STEP;
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters uPerf (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (state == HALT),
    .fetchEv      (accept && !redirect_valid),
    .stallEv      ((imem_req && !imem_ack) || (dec_valid && !dec_ready)),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory responder, decode-side monitor and directed scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        dec_ready = 1'b0;
  logic        inv_op;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        halted;
  logic        misalign;

  logic        d2Req;
  logic [63:0] d2Addr;
  logic        d2Valid;
  logic [31:0] d2Instr;
  logic [63:0] d2Pc;
  logic        d2Halted;
  logic        d2Mis;

  int          nAssert = 0;
  int          nFail = 0;
  int          ackDelay = 0;
  logic [63:0] scb[$];

  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (a == 64'h200) return 32'hFFFF_FFFF;
    return {a[26:2], 7'b0110011};
  endfunction

  assign imem_rdata = memWord(imem_addr);
  assign inv_op     = (dec_instr[6:0] == 7'h7F);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf1, ps1, pf2, ps2;
`endif

  instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready),
    .inv_op         (inv_op),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .misalign       (misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (pf1),
    .perf_stall     (ps1)
`endif
  );

  instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dutWrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (d2Req),
    .imem_addr      (d2Addr),
    .imem_ack       (1'b1),
    .imem_rdata     (32'h0000_0033),
    .dec_valid      (d2Valid),
    .dec_instr      (d2Instr),
    .dec_pc         (d2Pc),
    .dec_ready      (1'b1),
    .inv_op         (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (64'h0),
    .halted         (d2Halted),
    .misalign       (d2Mis)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (pf2),
    .perf_stall     (ps2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory: ack after ackDelay waiting cycles of a held request.
  initial begin
    int waitCnt;
    waitCnt  = 0;
    imem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_req && waitCnt >= ackDelay) begin
        imem_ack = 1'b1;
        waitCnt  = 0;
      end else begin
        imem_ack = 1'b0;
        waitCnt  = imem_req ? waitCnt + 1 : 0;
      end
    end
  end

  // Decode side: every accepted handshake must match the next scoreboard entry.
  initial begin
    logic [63:0] expPc;
    forever begin
      @(negedge clk);
      if (rst_n && dec_valid && dec_ready && !redirect_valid) begin
        chk("scb_avail", 64'(scb.size() > 0), 64'd1);
        if (scb.size() > 0) begin
          expPc = scb.pop_front();
          chk("dec_pc", dec_pc, expPc);
          chk("dec_instr", 64'(dec_instr), 64'(memWord(expPc)));
        end
      end
    end
  end

  task automatic doReset(input int dly, input logic rdy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = rdy;
    ackDelay       = dly;
    scb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitValid(input int maxc);
    int i;
    i = 0;
    while (!dec_valid && i < maxc) begin
      @(posedge clk); #1;
      i++;
    end
    chk("wait_valid", 64'(dec_valid), 64'd1);
  endtask

  task automatic waitDrain(input int maxc);
    int i;
    i = 0;
    while (scb.size() > 0 && i < maxc) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain", 64'(scb.size()), 64'd0);
    dec_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic sawValid;
    // Reset values
    dec_ready = 1'b1;
    #12;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_instr", 64'(dec_instr), 64'd0);
    chk("rst_dec_pc", dec_pc, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);

    // Zero-wait streaming, plus wrap-around on the second instance
    doReset(0, 1'b1);
    scb.push_back(64'h0); scb.push_back(64'h4); scb.push_back(64'h8);
    @(posedge clk); #1;
    chk("t1_idle_valid", 64'(dec_valid), 64'd0);
    chk("t1_req", 64'(imem_req), 64'd1);
    chk("wrap_addr0", d2Addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(posedge clk); #1;
    chk("t1_valid_lat", 64'(dec_valid), 64'd1);
    chk("wrap_dec_pc", d2Pc, 64'hFFFF_FFFF_FFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_addr1", d2Addr, 64'h0);
    chk("wrap_req1", 64'(d2Req), 64'd1);
    waitDrain(20);

    // Slow memory and decode back-pressure
    doReset(3, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait_req", 64'(imem_req), 64'd1);
      chk("t2_wait_addr", imem_addr, 64'h0);
      chk("t2_wait_valid", 64'(dec_valid), 64'd0);
      @(posedge clk); #1;
    end
    waitValid(5);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("t2_hold_valid", 64'(dec_valid), 64'd1);
      chk("t2_hold_pc", dec_pc, 64'h0);
      chk("t2_hold_instr", 64'(dec_instr), 64'(memWord(64'h0)));
      chk("t2_hold_addr", imem_addr, 64'h0);
    end
    scb.push_back(64'h0); scb.push_back(64'h4);
    dec_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_adv_addr", imem_addr, 64'h4);
    chk("t2_adv_req", 64'(imem_req), 64'd1);
    waitDrain(30);

    // Redirect while a request is outstanding
    doReset(3, 1'b1);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    chk("t3_addr_held", imem_addr, 64'h0);
    for (int i = 0; i < 10 && imem_addr != 64'h100; i++) begin
      @(posedge clk); #1;
    end
    chk("t3_new_addr", imem_addr, 64'h100);
    chk("t3_new_req", 64'(imem_req), 64'd1);
    scb.push_back(64'h100); scb.push_back(64'h104);
    waitDrain(40);

    // Misaligned redirect halts
    doReset(0, 1'b0);
    waitValid(10);
    chk("t4_hold_pc", dec_pc, 64'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h102;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    chk("t4_halted", 64'(halted), 64'd1);
    chk("t4_misalign", 64'(misalign), 64'd1);
    chk("t4_req", 64'(imem_req), 64'd0);
    chk("t4_valid", 64'(dec_valid), 64'd0);
    dec_ready = 1'b1;
    sawValid  = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      sawValid |= dec_valid | imem_req;
    end
    chk("t4_quiet", 64'(sawValid), 64'd0);
    chk("t4_pc_kept", imem_addr, 64'h0);
    dec_ready = 1'b0;

    // Invalid opcode accepted halts without misalign
    doReset(0, 1'b0);
    waitValid(10);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    waitValid(10);
    chk("t5_pc", dec_pc, 64'h200);
    scb.push_back(64'h200);
    dec_ready = 1'b1;
    @(posedge clk); #1;
    dec_ready = 1'b0;
    chk("t5_halted", 64'(halted), 64'd1);
    chk("t5_misalign", 64'(misalign), 64'd0);
    chk("t5_valid", 64'(dec_valid), 64'd0);
    chk("t5_req", 64'(imem_req), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_still_halted", 64'(halted), 64'd1);
    chk("t5_pc_kept", imem_addr, 64'h200);

    // Redirect beats invalid opcode
    doReset(0, 1'b0);
    waitValid(10);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    waitValid(10);
    chk("t5b_inv", 64'(inv_op), 64'd1);
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    chk("t5b_halted", 64'(halted), 64'd0);
    chk("t5b_req", 64'(imem_req), 64'd1);
    chk("t5b_addr", imem_addr, 64'h40);
    scb.push_back(64'h40);
    waitDrain(20);

    // Asynchronous reset in the middle of a request
    doReset(3, 1'b1);
    @(posedge clk); #1;
    chk("t6_req_before", 64'(imem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_async", 64'(imem_req), 64'd0);
    chk("t6_addr_async", imem_addr, 64'h0);
    scb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    scb.push_back(64'h0);
    waitDrain(30);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
